// File: rtl/dsc_pkg.sv
// Shared definitions for the clock-division DSC multiplier sequencer:
// default stream width, sequencer state type and the stream period helper.
package dsc_pkg;

  localparam int unsigned SNG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsc_seq_state_t;

  // Length of one unary stream period for a given operand width.
  function automatic int unsigned dsc_period(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/dsc_sng.sv
// Unary stream generator: a WIDTH-bit counter that runs while enabled,
// flags its last count, and emits bit_out = (ctr < bin).
module dsc_sng
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH = SNG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] ctr,
  output logic             wrap,
  output logic             bit_out
);

  localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(dsc_period(WIDTH) - 1);

  // Counter wraps naturally from CTR_MAX back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= '0;
    end else if (clr) begin
      ctr <= '0;
    end else if (en) begin
      ctr <= ctr + WIDTH'(1);
    end
  end

  assign wrap    = (ctr == CTR_MAX);
  assign bit_out = (ctr < bin);

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequencer for the clock-division deterministic stochastic multiplier.
// Accepts (a, b), runs stream A every clock and stream B once per A period,
// counts the ones of A&B and presents the exact product z = a*b.
// Optional macro DSC_EARLY_TERM_EN: zero operands skip the run entirely, and
// a run stops once stream B has emitted its last one.
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH = SNG_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(dsc_period(WIDTH) - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   ctr_a;
  logic [WIDTH-1:0]   ctr_b;
  logic [WIDTH-1:0]   stop_b;
  logic               wrap_a;
  logic               wrap_b;
  logic               bit_a;
  logic               bit_b;
  logic               accept;
  logic               run;
  logic               run_last;
  logic [2*WIDTH-1:0] acc;
  logic               unused_sink;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_DONE);
  assign run       = busy;
  assign accept    = in_valid && in_ready;
  assign z         = out_valid ? acc : '0;

`ifdef DSC_EARLY_TERM_EN
  // Zero b is bypassed at accept, so b_reg - 1 never underflows in RUN.
  assign stop_b = b_reg - WIDTH'(1);
`else
  assign stop_b = CTR_MAX;
`endif

  // Final RUN cycle: A at the end of its period and B on its last useful count.
  assign run_last = wrap_a && (ctr_b == stop_b);

  // B's wrap flag and A's count value are not needed by the schedule.
  assign unused_sink = ^{ctr_a, wrap_b};

  dsc_sng #(.WIDTH(WIDTH)) u_sng_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (run),
    .bin     (a_reg),
    .ctr     (ctr_a),
    .wrap    (wrap_a),
    .bit_out (bit_a)
  );

  dsc_sng #(.WIDTH(WIDTH)) u_sng_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (run && wrap_a),
    .bin     (b_reg),
    .ctr     (ctr_b),
    .wrap    (wrap_b),
    .bit_out (bit_b)
  );

  // Next-state selection; abort only matters while running and beats run_last.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_RUN;
`ifdef DSC_EARLY_TERM_EN
          if ((a == '0) || (b == '0)) begin
            state_nxt = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (run_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are captured only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // Ones counter of the AND stream; held untouched outside RUN so z stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (run) begin
      acc <= acc + (2*WIDTH)'(bit_a & bit_b);
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq at WIDTH=4: per-cycle comparison against a
// transaction-level model plus directed operations with literal results.
module tb_dsc_mul_seq;

  localparam int W = 4;
  localparam int P = 1 << W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           abort = 1'b0;
  logic           busy;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] z;

  int n_checks = 0;
  int n_fail   = 0;

  dsc_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  always #5 clk = ~clk;

  // Cycle index (1 = cycle right after accept) at which out_valid is first high.
  function automatic int exp_lat(input int ea, input int eb);
`ifdef DSC_EARLY_TERM_EN
    if (ea == 0 || eb == 0) return 1;
    return eb * P + 1;
`else
    return P * P + 1;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 = waiting for operands, 1 = running, 2 = holding result.
  int     m_mode = 0;
  int     m_left = 0;
  longint m_z    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_left = 0;
      m_z    = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          m_z    = longint'(a) * longint'(b);
          m_left = exp_lat(int'(a), int'(b)) - 1;
          m_mode = (m_left == 0) ? 2 : 1;
        end
        1: if (abort) begin
          m_mode = 0;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        2: if (out_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_in_ready", in_ready, (m_mode == 0));
      chk("cyc_busy", busy, (m_mode == 1));
      chk("cyc_out_valid", out_valid, (m_mode == 2));
      if (m_mode == 2) chk("cyc_z", z, m_z);
    end
  end

  task automatic start_op(input int ta, input int tb);
    in_valid = 1'b1;
    a = W'(ta);
    b = W'(tb);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    a = ~a;
    b = ~b;
  endtask

  task automatic wait_done(input string tag, input int elat);
    int k;
    int bc;
    k  = 1;
    bc = 0;
    while (!out_valid && k <= P * P + 8) begin
      if (busy) bc++;
      @(posedge clk);
      #2;
      k++;
    end
    chk({tag, "_seen"}, out_valid, 1);
    chk({tag, "_lat"}, k, elat);
    chk({tag, "_busy_cycles"}, bc, elat - 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    chk("take_drop", out_valid, 0);
    chk("take_ready", in_ready, 1);
  endtask

  task automatic do_op(input string tag, input int ta, input int tb, input int ez, input int hold);
    start_op(ta, tb);
    wait_done(tag, exp_lat(ta, tb));
    chk({tag, "_z"}, z, ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'(1);
      b = W'(1);
      abort = 1'b1;
      @(posedge clk);
      #2;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_z"}, z, ez);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    abort = 1'b0;
    take();
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    do_op("max", 15, 15, 225, 0);
    do_op("p8x2", 8, 2, 16, 0);
    do_op("zero_a", 0, 9, 0, 0);
    do_op("p9x3", 9, 3, 27, 0);
    do_op("bp", 7, 5, 35, 20);
    do_op("zero_b", 15, 0, 0, 0);

    // Abort in the middle of a run.
    start_op(5, 13);
    repeat (99) begin
      @(posedge clk);
      #2;
    end
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    repeat (300) begin
      @(posedge clk);
      #2;
    end
    chk("abort_no_valid", out_valid, 0);
    do_op("after_abort", 3, 4, 12, 0);

    // Abort coinciding with the last RUN cycle.
    start_op(6, 7);
    repeat (exp_lat(6, 7) - 2) begin
      @(posedge clk);
      #2;
    end
    chk("abort_last_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    chk("abort_last_valid", out_valid, 0);
    chk("abort_last_ready", in_ready, 1);

    // Asynchronous reset mid-run.
    start_op(9, 9);
    repeat (50) begin
      @(posedge clk);
      #2;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("arst_run_busy", busy, 0);
    chk("arst_run_valid", out_valid, 0);
    chk("arst_run_z", z, 0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("arst_run_ready", in_ready, 1);

    // Asynchronous reset while a result is pending.
    start_op(2, 3);
    wait_done("pre_rst", exp_lat(2, 3));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_done_valid", out_valid, 0);
    chk("arst_done_z", z, 0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("arst_done_ready", in_ready, 1);

    do_op("one", 1, 1, 1, 0);
    do_op("b2b", 15, 14, 210, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
